// File: rtl/line_clear_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_clear_ctrl_pkg
// Description : Shared playfield definitions. These are the tile encoding,
//               the row-wide tile vector and the row index type. The
//               line-clear sequencer and its row checker use them.
// Revision    : 1.0 - initial release
// ============================================================================
package line_clear_ctrl_pkg;

    localparam int PLAYFIELD_ROWS = 20;
    localparam int PLAYFIELD_COLS = 10;
    localparam int ROW_IDX_WIDTH  = $clog2(PLAYFIELD_ROWS);

    typedef enum logic [3:0] {
        BLANK   = 4'd0,
        I       = 4'd1,
        O       = 4'd2,
        T       = 4'd3,
        S       = 4'd4,
        Z       = 4'd5,
        J       = 4'd6,
        L       = 4'd7,
        GHOST   = 4'd8,
        GARBAGE = 4'd9
    } tile_type_t;

    typedef logic [ROW_IDX_WIDTH-1:0]        row_idx_t;
    typedef tile_type_t [PLAYFIELD_COLS-1:0] tile_row_t;

    // Row with every tile BLANK. It is used for fill writes and for idle bus values.
    function automatic tile_row_t blank_row();
        tile_row_t r;
        for (int i = 0; i < PLAYFIELD_COLS; i++) begin
            r[i] = BLANK;
        end
        return r;
    endfunction

endpackage : line_clear_ctrl_pkg
`default_nettype wire

// File: rtl/line_clear_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : line_clear_ctrl_if
// Description : Bundles the lock-event handshake and the playfield RAM ports
//               of the line-clear sequencer.
//               slave  : the sequencer side. It takes start and rd_data and
//                        drives everything else.
//               master : the game-logic and RAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface line_clear_ctrl_if;
    import line_clear_ctrl_pkg::*;

    logic      start;
    logic      busy;
    logic      done;
    logic [4:0] lines_cleared;
    row_idx_t  rd_row;
    tile_row_t rd_data;
    logic      wr_en;
    row_idx_t  wr_row;
    tile_row_t wr_data;

    modport slave (
        input  start, rd_data,
        output busy, done, lines_cleared, rd_row, wr_en, wr_row, wr_data
    );

    modport master (
        output start, rd_data,
        input  busy, done, lines_cleared, rd_row, wr_en, wr_row, wr_data
    );
endinterface : line_clear_ctrl_if
`default_nettype wire

// File: rtl/line_clear_ctrl_row_full_check.sv
`default_nettype none
// ============================================================================
// Module      : row_full_check
// Description : Combinational full-row detector. A row is full when no tile
//               is BLANK or GHOST.
// Ports       : row  - tile row under test
//               full - high when every column is occupied
// Revision    : 1.0 - initial release
// ============================================================================
module row_full_check
    import line_clear_ctrl_pkg::*;
#(
    parameter int COLS = PLAYFIELD_COLS
) (
    input  tile_row_t row,
    output logic      full
);
    always_comb begin
        full = 1'b1;
        for (int i = 0; i < COLS; i++) begin
            // A ghost is only a drop preview. It does not count as a placed tile.
            if (row[i] == BLANK || row[i] == GHOST) begin
                full = 1'b0;
            end
        end
    end
endmodule : row_full_check
`default_nettype wire

// File: rtl/line_clear_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : line_clear_ctrl
// Description : Line-clear sequencer. It scans the playfield from the bottom
//               row to the top, drops full rows and compacts the remaining
//               rows downward. It then blank-fills the vacated top rows.
// Ports       : clk, rst - clock and asynchronous active-high reset
//               lc       - start/busy/done/lines_cleared handshake plus the
//                          playfield RAM read port (1-cycle latency) and
//                          write port
// Revision    : 1.0 - initial release
// ============================================================================
module line_clear_ctrl
    import line_clear_ctrl_pkg::*;
#(
    parameter int ROWS = PLAYFIELD_ROWS,
    parameter int COLS = PLAYFIELD_COLS
) (
    input  wire               clk,
    input  wire               rst,
    line_clear_ctrl_if.slave  lc
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CHECK = 3'd2,
        S_FILL  = 3'd3,
        S_DONE  = 3'd4
    } lc_state_t;

    lc_state_t  state_q, state_d;
    row_idx_t   src_q, src_d;     // next row to read
    row_idx_t   dst_q, dst_d;     // next row to write; dst >= src always
    logic [4:0] count_q, count_d;
    logic       w_full;

    row_full_check #(.COLS(COLS)) u_row_full_check (
        .row  (lc.rd_data),
        .full (w_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        count_d    = count_q;
        lc.wr_en   = 1'b0;
        lc.wr_row  = '0;
        lc.wr_data = blank_row();

        unique case (state_q)
            S_IDLE: begin
                if (lc.start) begin
                    state_d = S_READ;
                    src_d   = row_idx_t'(ROWS - 1);
                    dst_d   = row_idx_t'(ROWS - 1);
                    count_d = '0;
                end
            end
            S_READ: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (w_full) begin
                    count_d = count_q + 5'd1;
                end else begin
                    // A row that is already in place needs no rewrite.
                    if (src_q != dst_q) begin
                        lc.wr_en   = 1'b1;
                        lc.wr_row  = dst_q;
                        lc.wr_data = lc.rd_data;
                    end
                    dst_d = dst_q - row_idx_t'(1);
                end
                if (src_q == '0) begin
                    // After the last row, dst is still valid exactly when some rows were cleared.
                    state_d = (count_d != '0) ? S_FILL : S_DONE;
                end else begin
                    src_d   = src_q - row_idx_t'(1);
                    state_d = S_READ;
                end
            end
            S_FILL: begin
                lc.wr_en  = 1'b1;
                lc.wr_row = dst_q;
                dst_d     = dst_q - row_idx_t'(1);
                if (dst_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The read address holds src through READ and CHECK, so the RAM output lines up in CHECK.
    assign lc.rd_row        = src_q;
    assign lc.busy          = (state_q != S_IDLE);
    assign lc.done          = (state_q == S_DONE);
    assign lc.lines_cleared = count_q;

endmodule : line_clear_ctrl
`default_nettype wire

// File: tb/tb_line_clear_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_clear_ctrl
// Description : Directed self-checking bench for line_clear_ctrl. It holds a
//               behavioural playfield RAM with a registered 1-cycle read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_clear_ctrl;
    import line_clear_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    line_clear_ctrl_if lc_if ();

    line_clear_ctrl #(.ROWS(PLAYFIELD_ROWS), .COLS(PLAYFIELD_COLS)) dut (
        .clk (clk),
        .rst (rst),
        .lc  (lc_if.slave)
    );

    always #5 clk = ~clk;

    tile_row_t mem [PLAYFIELD_ROWS];
    tile_row_t rd_q;
    assign lc_if.rd_data = rd_q;

    always @(posedge clk) begin
        if (lc_if.wr_en) mem[lc_if.wr_row] <= lc_if.wr_data;
        rd_q <= mem[lc_if.rd_row];
    end

    int        wr_rows [$];
    tile_row_t wr_datas [$];

    function automatic tile_row_t fill_row(tile_type_t t);
        tile_row_t r;
        for (int i = 0; i < PLAYFIELD_COLS; i++) r[i] = t;
        return r;
    endfunction

    task automatic clear_field();
        for (int r = 0; r < PLAYFIELD_ROWS; r++) mem[r] = fill_row(BLANK);
    endtask

    // Entered and left at posedge+1. It pulses start into E0 and then records writes until done.
    task automatic run_pass(output int done_cyc, output int nwr, output logic [4:0] lines);
        wr_rows.delete();
        wr_datas.delete();
        done_cyc = -1;
        nwr      = 0;
        lines    = 5'h1f;
        lc_if.start = 1'b1;
        @(posedge clk); #1;
        lc_if.start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (lc_if.wr_en) begin
                nwr++;
                wr_rows.push_back(int'(lc_if.wr_row));
                wr_datas.push_back(lc_if.wr_data);
            end
            if (lc_if.done) begin
                done_cyc = c;
                lines    = lc_if.lines_cleared;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++;
        if (lc_if.busy !== 1'b0 || lc_if.done !== 1'b0 || lc_if.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl busy=%b done=%b wr_en=%b required 0 0 0",
                     lc_if.busy, lc_if.done, lc_if.wr_en);
        end
        checks++;
        if (lc_if.rd_row !== 5'd0 || lc_if.wr_row !== 5'd0) begin
            errors++;
            $display("FAIL reset_rows rd_row=%0d wr_row=%0d required 0 0", lc_if.rd_row, lc_if.wr_row);
        end
        checks++;
        if (lc_if.wr_data !== fill_row(BLANK) || lc_if.lines_cleared !== 5'd0) begin
            errors++;
            $display("FAIL reset_data wr_data=%h lines=%0d required %h 0",
                     lc_if.wr_data, lc_if.lines_cleared, fill_row(BLANK));
        end
    endtask

    task automatic test_empty();
        int dc, nw; logic [4:0] ln;
        clear_field();
        run_pass(dc, nw, ln);
        checks++;
        if (dc !== 41) begin errors++; $display("FAIL empty_done cycle=%0d required 41", dc); end
        checks++;
        if (nw !== 0) begin errors++; $display("FAIL empty_writes got=%0d required 0", nw); end
        checks++;
        if (ln !== 5'd0) begin errors++; $display("FAIL empty_lines got=%0d required 0", ln); end
    endtask

    task automatic test_single();
        int dc, nw; logic [4:0] ln; tile_row_t pat;
        int bad;
        clear_field();
        pat = fill_row(BLANK);
        for (int i = 0; i < 4; i++) pat[i] = T;
        mem[19] = fill_row(GARBAGE);
        mem[18] = pat;
        run_pass(dc, nw, ln);
        checks++;
        if (dc !== 42 || ln !== 5'd1) begin
            errors++; $display("FAIL single_done cycle=%0d lines=%0d required 42 1", dc, ln);
        end
        checks++;
        if (nw !== 20) begin errors++; $display("FAIL single_writes got=%0d required 20", nw); end
        checks++;
        if (nw < 1 || wr_rows[0] !== 19 || wr_datas[0] !== pat) begin
            errors++; $display("FAIL single_first_write count=%0d required row 19 data %h", nw, pat);
        end
        checks++;
        if (nw != 20 || wr_rows[18] !== 1 || wr_rows[19] !== 0 || wr_datas[19] !== fill_row(BLANK)) begin
            errors++; $display("FAIL single_last_writes count=%0d required rows 1 then 0 blank", nw);
        end
        bad = 0;
        for (int r = 0; r < 19; r++) if (mem[r] !== fill_row(BLANK)) bad++;
        checks++;
        if (mem[19] !== pat || bad !== 0) begin
            errors++; $display("FAIL single_field row19=%h nonblank_above=%0d required %h 0", mem[19], bad, pat);
        end
    endtask

    task automatic setup_double(output tile_row_t pa, output tile_row_t pb);
        clear_field();
        pa = fill_row(BLANK);
        pb = fill_row(BLANK);
        for (int i = 0; i < PLAYFIELD_COLS; i += 2) pa[i] = S;
        pb[9] = Z;
        pb[0] = J;
        mem[19] = fill_row(I);
        mem[18] = pa;
        mem[17] = fill_row(I);
        mem[16] = pb;
    endtask

    task automatic test_double();
        int dc, nw; logic [4:0] ln; tile_row_t pa, pb;
        int bad;
        setup_double(pa, pb);
        run_pass(dc, nw, ln);
        checks++;
        if (dc !== 43 || ln !== 5'd2) begin
            errors++; $display("FAIL double_done cycle=%0d lines=%0d required 43 2", dc, ln);
        end
        checks++;
        if (nw !== 20) begin errors++; $display("FAIL double_writes got=%0d required 20", nw); end
        bad = 0;
        for (int r = 0; r < 18; r++) if (mem[r] !== fill_row(BLANK)) bad++;
        checks++;
        if (mem[19] !== pa || mem[18] !== pb || bad !== 0) begin
            errors++; $display("FAIL double_field r19=%h r18=%h nonblank=%0d required %h %h 0",
                               mem[19], mem[18], bad, pa, pb);
        end
    endtask

    task automatic test_ghost();
        int dc, nw; logic [4:0] ln; tile_row_t pg;
        clear_field();
        pg = fill_row(L);
        pg[5] = GHOST;
        mem[19] = pg;
        run_pass(dc, nw, ln);
        checks++;
        if (nw !== 0 || ln !== 5'd0) begin
            errors++; $display("FAIL ghost_clear writes=%0d lines=%0d required 0 0", nw, ln);
        end
        checks++;
        if (dc !== 41 || mem[19] !== pg) begin
            errors++; $display("FAIL ghost_field done=%0d r19=%h required 41 %h", dc, mem[19], pg);
        end
    endtask

    task automatic test_start_handling();
        int bad_busy, ndone, dcyc, d2;
        clear_field();
        bad_busy = 0; ndone = 0; dcyc = -1;
        lc_if.start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 45; c++) begin
            if (lc_if.busy !== (c <= 41)) bad_busy++;
            if (lc_if.done) begin ndone++; dcyc = c; end
            lc_if.start = (c <= 2) || (c == 20);
            @(posedge clk); #1;
        end
        lc_if.start = 1'b0;
        checks++;
        if (bad_busy !== 0) begin errors++; $display("FAIL start_busy bad_cycles=%0d required 0", bad_busy); end
        checks++;
        if (ndone !== 1 || dcyc !== 41) begin
            errors++; $display("FAIL start_single_pass dones=%0d at=%0d required 1 at 41", ndone, dcyc);
        end

        // start held through DONE re-arms after one IDLE cycle
        lc_if.start = 1'b1;
        d2 = -1;
        @(posedge clk); #1;
        for (int c = 1; c <= 100; c++) begin
            if (c == 42) begin
                checks++;
                if (lc_if.busy !== 1'b0) begin errors++; $display("FAIL retrigger_idle busy=%b required 0", lc_if.busy); end
            end
            if (c == 43) begin
                checks++;
                if (lc_if.busy !== 1'b1) begin errors++; $display("FAIL retrigger_busy busy=%b required 1", lc_if.busy); end
                lc_if.start = 1'b0;
            end
            if (c > 43 && lc_if.done) begin d2 = c; break; end
            @(posedge clk); #1;
        end
        lc_if.start = 1'b0;
        checks++;
        if (d2 !== 83) begin errors++; $display("FAIL retrigger_done cycle=%0d required 83", d2); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        tile_row_t pa, pb;
        int early_done, late_bad;
        setup_double(pa, pb);
        early_done = 0; late_bad = 0;
        lc_if.start = 1'b1;
        @(posedge clk); #1;
        lc_if.start = 1'b0;
        for (int c = 1; c < 41; c++) begin
            if (lc_if.done) early_done++;
            @(posedge clk); #1;
        end
        checks++;
        if (lc_if.wr_en !== 1'b1 || early_done !== 0) begin
            errors++; $display("FAIL midreset_fill wr_en=%b early_done=%0d required 1 0", lc_if.wr_en, early_done);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (lc_if.wr_en !== 1'b0 || lc_if.busy !== 1'b0 || lc_if.lines_cleared !== 5'd0) begin
            errors++; $display("FAIL midreset_async wr_en=%b busy=%b lines=%0d required 0 0 0",
                               lc_if.wr_en, lc_if.busy, lc_if.lines_cleared);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            if (lc_if.done !== 1'b0 || lc_if.busy !== 1'b0 || lc_if.lines_cleared !== 5'd0) late_bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (late_bad !== 0) begin errors++; $display("FAIL midreset_idle bad_cycles=%0d required 0", late_bad); end
    endtask

    initial begin
        lc_if.start = 1'b0;
        clear_field();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        #3 rst = 1'b0;
        @(posedge clk); #1;
        test_empty();
        test_single();
        test_double();
        test_ghost();
        test_start_handling();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_line_clear_ctrl
`default_nettype wire
